// File: rtl/parking_pkg.sv
// Shared types and default timing constants for the parking gate front-end.
// Both lanes and the top level import this package.
package parking_pkg;

  localparam int unsigned CNT_W                   = 32;
  localparam int unsigned DEF_DEBOUNCE_CYCLES     = 100_000;
  localparam int unsigned DEF_PASS_TIMEOUT_CYCLES = 1_500_000_000;

  typedef logic [CNT_W-1:0] count_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BADGE,
    OPEN,
    PASSING,
    COMMIT
  } lane_state_e;

endpackage

// File: rtl/gate_lane_fsm.sv
// One barrier lane: sensor synchronizers and debouncers, the lane FSM,
// the pass timeout counter and the req/grant handshake toward the arbiter.
module gate_lane_fsm
  import parking_pkg::*;
#(
  parameter bit          IS_ENTRY            = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned PASS_TIMEOUT_CYCLES = DEF_PASS_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic arrive_i,
  input  logic pass_i,
  input  logic badge_valid_i,
  input  logic badge_uni_i,
  input  logic uni_vacated_i,
  input  logic vacated_i,
  input  logic grant_i,
  output logic req_o,
  output logic req_uni_o,
  output logic barrier_open_o,
  output logic reject_o,
  output logic timeout_o
);

  localparam count_t DEB_LAST = count_t'(DEBOUNCE_CYCLES - 1);
  localparam count_t TMO_LAST = count_t'(PASS_TIMEOUT_CYCLES - 1);

  // Sensor bit 0 is arrive, bit 1 is pass.
  logic [1:0]            raw;
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            deb_q, deb_d;
  logic [1:0]            debPrev_q;
  logic [1:0][CNT_W-1:0] debCnt_q, debCnt_d;

  lane_state_e state_q, state_d;
  count_t      tmoCnt_q, tmoCnt_d;
  logic        uni_q, uni_d;
  logic        reject_q, reject_d;
  logic        timeout_q, timeout_d;

  logic arriveDeb, passRise, passFall, accept;

  assign raw = {pass_i, arrive_i};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      debPrev_q <= '0;
      debCnt_q  <= '0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      debPrev_q <= deb_q;
      debCnt_q  <= debCnt_d;
    end
  end

  // A level is accepted only after it has differed for DEBOUNCE_CYCLES in a row.
  always_comb begin
    deb_d    = deb_q;
    debCnt_d = '0;
    for (int s = 0; s < 2; s++) begin
      if (sync2_q[s] != deb_q[s]) begin
        if (debCnt_q[s] == DEB_LAST) begin
          deb_d[s] = sync2_q[s];
        end else begin
          debCnt_d[s] = debCnt_q[s] + 1'b1;
        end
      end
    end
  end

  assign arriveDeb = deb_q[0];
  assign passRise  = deb_q[1] & ~debPrev_q[1];
  assign passFall  = ~deb_q[1] & debPrev_q[1];

  // The exit lane always admits; the entry lane checks the flag matching the badge.
  assign accept = !IS_ENTRY || (badge_uni_i ? uni_vacated_i : vacated_i);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tmoCnt_q  <= '0;
      uni_q     <= 1'b0;
      reject_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmoCnt_q  <= tmoCnt_d;
      uni_q     <= uni_d;
      reject_q  <= reject_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmoCnt_d  = tmoCnt_q;
    uni_d     = uni_q;
    reject_d  = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arriveDeb) state_d = WAIT_BADGE;
      end
      WAIT_BADGE: begin
        if (!arriveDeb) begin
          state_d = IDLE;
        end else if (badge_valid_i) begin
          if (accept) begin
            state_d  = OPEN;
            uni_d    = badge_uni_i;
            tmoCnt_d = '0;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      OPEN: begin
        if (passRise) begin
          state_d = PASSING;
        end else if (tmoCnt_q == TMO_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else if (tmoCnt_q != '1) begin
          tmoCnt_d = tmoCnt_q + 1'b1;
        end
      end
      PASSING: begin
        if (passFall) state_d = COMMIT;
      end
      COMMIT: begin
        if (grant_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_o          = (state_q == COMMIT);
  assign req_uni_o      = uni_q;
  assign barrier_open_o = (state_q == OPEN) || (state_q == PASSING);
  assign reject_o       = reject_q;
  assign timeout_o      = timeout_q;

endmodule

// File: rtl/parking_gate_controller.sv
// Parking gate front-end: two lane controllers plus the entry-first arbiter
// that turns completed passages into single-cycle, never-simultaneous events.
module parking_gate_controller
  import parking_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned PASS_TIMEOUT_CYCLES = DEF_PASS_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic in_arrive,
  input  logic in_pass,
  input  logic in_badge_valid,
  input  logic in_badge_uni,
  input  logic out_arrive,
  input  logic out_pass,
  input  logic out_badge_valid,
  input  logic out_badge_uni,
  input  logic uni_is_vacated_space,
  input  logic is_vacated_space,
  output logic in_barrier_open,
  output logic out_barrier_open,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic car_exited,
  output logic is_uni_car_exited,
  output logic in_reject,
  output logic in_timeout,
  output logic out_timeout
);

  logic entryReq, entryReqUni, entryGrant, entryReject;
  logic exitReq, exitReqUni, exitGrant, exitReject;
  logic carEntered_q, uniEntered_q, carExited_q, uniExited_q;

  gate_lane_fsm #(
    .IS_ENTRY           (1'b1),
    .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
    .PASS_TIMEOUT_CYCLES(PASS_TIMEOUT_CYCLES)
  ) u_entry (
    .clk           (clk),
    .reset         (reset),
    .arrive_i      (in_arrive),
    .pass_i        (in_pass),
    .badge_valid_i (in_badge_valid),
    .badge_uni_i   (in_badge_uni),
    .uni_vacated_i (uni_is_vacated_space),
    .vacated_i     (is_vacated_space),
    .grant_i       (entryGrant),
    .req_o         (entryReq),
    .req_uni_o     (entryReqUni),
    .barrier_open_o(in_barrier_open),
    .reject_o      (entryReject),
    .timeout_o     (in_timeout)
  );

  gate_lane_fsm #(
    .IS_ENTRY           (1'b0),
    .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
    .PASS_TIMEOUT_CYCLES(PASS_TIMEOUT_CYCLES)
  ) u_exit (
    .clk           (clk),
    .reset         (reset),
    .arrive_i      (out_arrive),
    .pass_i        (out_pass),
    .badge_valid_i (out_badge_valid),
    .badge_uni_i   (out_badge_uni),
    .uni_vacated_i (uni_is_vacated_space),
    .vacated_i     (is_vacated_space),
    .grant_i       (exitGrant),
    .req_o         (exitReq),
    .req_uni_o     (exitReqUni),
    .barrier_open_o(out_barrier_open),
    .reject_o      (exitReject),
    .timeout_o     (out_timeout)
  );

  // Entry wins a tie; the exit lane simply holds its request one more cycle.
  assign entryGrant = entryReq;
  assign exitGrant  = exitReq & ~entryReq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carEntered_q <= 1'b0;
      uniEntered_q <= 1'b0;
      carExited_q  <= 1'b0;
      uniExited_q  <= 1'b0;
    end else begin
      carEntered_q <= entryGrant;
      uniEntered_q <= entryGrant & entryReqUni;
      carExited_q  <= exitGrant;
      uniExited_q  <= exitGrant & exitReqUni;
    end
  end

  assign car_entered        = carEntered_q;
  assign is_uni_car_entered = uniEntered_q;
  assign car_exited         = carExited_q;
  assign is_uni_car_exited  = uniExited_q;

  // The exit lane never refuses a badge, so this is the entry pulse alone.
  assign in_reject = entryReject | exitReject;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Self-checking bench for parking_gate_controller: a cycle-level behavioural
// model of both lanes plus directed scenarios with hand-computed expectations.
module tb_parking_gate_controller;

  localparam int DEB = 4;
  localparam int PTO = 50;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_arrive = 1'b0, in_pass = 1'b0, in_badge_valid = 1'b0, in_badge_uni = 1'b0;
  logic out_arrive = 1'b0, out_pass = 1'b0, out_badge_valid = 1'b0, out_badge_uni = 1'b0;
  logic uni_is_vacated_space = 1'b0, is_vacated_space = 1'b0;
  logic in_barrier_open, out_barrier_open;
  logic car_entered, is_uni_car_entered, car_exited, is_uni_car_exited;
  logic in_reject, in_timeout, out_timeout;

  int checks = 0;
  int errors = 0;
  bit cmpOn = 1'b0;

  parking_gate_controller #(
    .DEBOUNCE_CYCLES    (DEB),
    .PASS_TIMEOUT_CYCLES(PTO)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .in_arrive           (in_arrive),
    .in_pass             (in_pass),
    .in_badge_valid      (in_badge_valid),
    .in_badge_uni        (in_badge_uni),
    .out_arrive          (out_arrive),
    .out_pass            (out_pass),
    .out_badge_valid     (out_badge_valid),
    .out_badge_uni       (out_badge_uni),
    .uni_is_vacated_space(uni_is_vacated_space),
    .is_vacated_space    (is_vacated_space),
    .in_barrier_open     (in_barrier_open),
    .out_barrier_open    (out_barrier_open),
    .car_entered         (car_entered),
    .is_uni_car_entered  (is_uni_car_entered),
    .car_exited          (car_exited),
    .is_uni_car_exited   (is_uni_car_exited),
    .in_reject           (in_reject),
    .in_timeout          (in_timeout),
    .out_timeout         (out_timeout)
  );

  always #5 clk = ~clk;

  // Model: a lane is either free, holding a waiting car, gate up, car under
  // the gate, or holding a finished passage waiting to be logged.
  bit [DEB+1:0] mHist [2][2];
  bit mDeb [2][2];
  bit mDebPrev [2][2];
  bit mPresent [2];
  bit mOpen [2];
  bit mUnder [2];
  bit mPending [2];
  bit mUni [2];
  int mAge [2];
  bit expBarrier [2];
  bit expTimeout [2];
  bit expCar [2];
  bit expUni [2];
  bit expReject = 1'b0;

  always @(posedge clk or posedge reset) begin : model
    bit rawNow [2][2];
    bit bv [2];
    bit bu [2];
    bit gnt [2];
    bit ok, arr, rise, fall, allDiffer;
    if (reset) begin
      for (int l = 0; l < 2; l++) begin
        for (int s = 0; s < 2; s++) begin
          mHist[l][s] = '0; mDeb[l][s] = 1'b0; mDebPrev[l][s] = 1'b0;
        end
        mPresent[l] = 1'b0; mOpen[l] = 1'b0; mUnder[l] = 1'b0; mPending[l] = 1'b0;
        mUni[l] = 1'b0; mAge[l] = 0;
        expBarrier[l] = 1'b0; expTimeout[l] = 1'b0; expCar[l] = 1'b0; expUni[l] = 1'b0;
      end
      expReject = 1'b0;
    end else begin
      rawNow[0][0] = in_arrive;  rawNow[0][1] = in_pass;
      rawNow[1][0] = out_arrive; rawNow[1][1] = out_pass;
      bv[0] = in_badge_valid;  bu[0] = in_badge_uni;
      bv[1] = out_badge_valid; bu[1] = out_badge_uni;
      gnt[0] = mPending[0];
      gnt[1] = mPending[1] && !mPending[0];
      expReject = 1'b0;
      for (int l = 0; l < 2; l++) begin
        expCar[l] = gnt[l];
        expUni[l] = gnt[l] && mUni[l];
        expTimeout[l] = 1'b0;
        arr  = mDeb[l][0];
        rise = mDeb[l][1] && !mDebPrev[l][1];
        fall = !mDeb[l][1] && mDebPrev[l][1];
        if (mPending[l]) begin
          if (gnt[l]) mPending[l] = 1'b0;
        end else if (mUnder[l]) begin
          if (fall) begin mUnder[l] = 1'b0; mPending[l] = 1'b1; end
        end else if (mOpen[l]) begin
          if (rise) begin
            mOpen[l] = 1'b0; mUnder[l] = 1'b1;
          end else if (mAge[l] == PTO - 1) begin
            mOpen[l] = 1'b0; expTimeout[l] = 1'b1;
          end else begin
            mAge[l] = mAge[l] + 1;
          end
        end else if (mPresent[l]) begin
          if (!arr) begin
            mPresent[l] = 1'b0;
          end else if (bv[l]) begin
            ok = (l == 1) || (bu[l] ? uni_is_vacated_space : is_vacated_space);
            if (ok) begin
              mPresent[l] = 1'b0; mOpen[l] = 1'b1; mAge[l] = 0; mUni[l] = bu[l];
            end else begin
              expReject = 1'b1;
            end
          end
        end else if (arr) begin
          mPresent[l] = 1'b1;
        end
        expBarrier[l] = mOpen[l] || mUnder[l];
      end
      // Sensor seen two cycles late; accepted after DEB consecutive differing samples.
      for (int l = 0; l < 2; l++) begin
        for (int s = 0; s < 2; s++) begin
          mDebPrev[l][s] = mDeb[l][s];
          mHist[l][s] = {mHist[l][s][DEB:0], rawNow[l][s]};
          allDiffer = 1'b1;
          for (int j = 2; j < DEB + 2; j++) begin
            if (mHist[l][s][j] == mDeb[l][s]) allDiffer = 1'b0;
          end
          if (allDiffer) mDeb[l][s] = !mDeb[l][s];
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (cmpOn) begin
      checkOutput("in_barrier_open", in_barrier_open, expBarrier[0]);
      checkOutput("out_barrier_open", out_barrier_open, expBarrier[1]);
      checkOutput("car_entered", car_entered, expCar[0]);
      checkOutput("is_uni_car_entered", is_uni_car_entered, expUni[0]);
      checkOutput("car_exited", car_exited, expCar[1]);
      checkOutput("is_uni_car_exited", is_uni_car_exited, expUni[1]);
      checkOutput("in_reject", in_reject, expReject);
      checkOutput("in_timeout", in_timeout, expTimeout[0]);
      checkOutput("out_timeout", out_timeout, expTimeout[1]);
      checkOutput("events_exclusive", car_entered & car_exited, 1'b0);
    end
  end

  task automatic applyStimulus(input int lane, input bit arrive, input bit pass,
                               input bit badgeValid, input bit badgeUni);
    if (lane == 0) begin
      in_arrive = arrive; in_pass = pass; in_badge_valid = badgeValid; in_badge_uni = badgeUni;
    end else begin
      out_arrive = arrive; out_pass = pass; out_badge_valid = badgeValid; out_badge_uni = badgeUni;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic laneRandom(input int lane, input int n);
    bit a = 1'b0;
    bit p = 1'b0;
    int aLeft = 0;
    int pLeft = 0;
    repeat (n) begin
      @(negedge clk);
      if (aLeft == 0) begin a = 1'($urandom_range(0, 1)); aLeft = $urandom_range(1, 16); end
      else aLeft--;
      if (pLeft == 0) begin p = 1'($urandom_range(0, 1)); pLeft = $urandom_range(1, 20); end
      else pLeft--;
      applyStimulus(lane, a, p, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic flagsRandom(input int n);
    repeat (n) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) uni_is_vacated_space = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) is_vacated_space = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin : main
    bit sawEvent;
    #2 reset = 1'b1;
    #1;
    checkOutput("reset_barrier", in_barrier_open, 1'b0);
    checkOutput("reset_event", car_entered, 1'b0);
    cmpOn = 1'b1;
    step(3);
    reset = 1'b0;

    // 1: university entry with space, full passage.
    $display("[TB] scenario 1: university entry");
    uni_is_vacated_space = 1'b1; is_vacated_space = 1'b0;
    applyStimulus(0, 1, 0, 0, 0);
    step(10);
    checkOutput("s1_closed_before_badge", in_barrier_open, 1'b0);
    applyStimulus(0, 1, 0, 1, 1);
    nextEdge();
    checkOutput("s1_open_at_badge_plus1", in_barrier_open, 1'b1);
    @(negedge clk);
    applyStimulus(0, 1, 1, 0, 0);
    step(12);
    checkOutput("s1_open_while_passing", in_barrier_open, 1'b1);
    applyStimulus(0, 0, 0, 0, 0);
    repeat (6) nextEdge();
    checkOutput("s1_open_at_deb_fall", in_barrier_open, 1'b1);
    nextEdge();
    checkOutput("s1_closed_at_commit", in_barrier_open, 1'b0);
    checkOutput("s1_no_event_at_commit", car_entered, 1'b0);
    nextEdge();
    checkOutput("s1_event", car_entered, 1'b1);
    checkOutput("s1_event_uni", is_uni_car_entered, 1'b1);
    nextEdge();
    checkOutput("s1_event_single", car_entered, 1'b0);
    @(negedge clk);
    step(4);

    // 3: arrive glitches of 1..3 cycles must not arm the lane.
    $display("[TB] scenario 3: sensor glitches");
    for (int n = 1; n <= 3; n++) begin
      applyStimulus(0, 1, 0, 0, 0);
      step(n);
      applyStimulus(0, 0, 0, 0, 0);
      step(4);
      applyStimulus(0, 0, 0, 1, 1);
      nextEdge();
      checkOutput("s3_glitch_ignored", in_barrier_open, 1'b0);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0);
      step(8);
    end

    // 2 + 4: refused badge, then accepted, then timeout with a pass glitch.
    $display("[TB] scenario 2/4: reject then timeout");
    uni_is_vacated_space = 1'b1; is_vacated_space = 1'b0;
    applyStimulus(0, 1, 0, 0, 0);
    step(10);
    applyStimulus(0, 1, 0, 1, 0);
    nextEdge();
    checkOutput("s2_reject_pulse", in_reject, 1'b1);
    checkOutput("s2_reject_closed", in_barrier_open, 1'b0);
    @(negedge clk);
    applyStimulus(0, 1, 0, 0, 0);
    nextEdge();
    checkOutput("s2_reject_single", in_reject, 1'b0);
    @(negedge clk);
    uni_is_vacated_space = 1'b0; is_vacated_space = 1'b1;
    applyStimulus(0, 1, 0, 1, 0);
    nextEdge();
    checkOutput("s2_open_after_space", in_barrier_open, 1'b1);
    @(negedge clk);
    is_vacated_space = 1'b0;
    applyStimulus(0, 1, 1, 0, 0);
    step(3);
    applyStimulus(0, 1, 0, 0, 0);
    repeat (46) nextEdge();
    checkOutput("s4_open_before_timeout", in_barrier_open, 1'b1);
    checkOutput("s4_no_timeout_yet", in_timeout, 1'b0);
    nextEdge();
    checkOutput("s4_timeout_pulse", in_timeout, 1'b1);
    checkOutput("s4_closed_on_timeout", in_barrier_open, 1'b0);
    checkOutput("s4_no_event", car_entered, 1'b0);
    nextEdge();
    checkOutput("s4_timeout_single", in_timeout, 1'b0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 0);
    step(10);

    // 5: both lanes commit together; entry first, exit one cycle later.
    $display("[TB] scenario 5: simultaneous commit");
    uni_is_vacated_space = 1'b1; is_vacated_space = 1'b1;
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    step(10);
    applyStimulus(0, 1, 0, 1, 1);
    applyStimulus(1, 1, 0, 1, 1);
    nextEdge();
    checkOutput("s5_entry_open", in_barrier_open, 1'b1);
    checkOutput("s5_exit_open", out_barrier_open, 1'b1);
    @(negedge clk);
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(1, 1, 1, 0, 0);
    step(12);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    repeat (7) nextEdge();
    checkOutput("s5_exit_closed", out_barrier_open, 1'b0);
    nextEdge();
    checkOutput("s5_entered_at_T", car_entered, 1'b1);
    checkOutput("s5_no_exit_at_T", car_exited, 1'b0);
    nextEdge();
    checkOutput("s5_entered_done", car_entered, 1'b0);
    checkOutput("s5_exited_at_T1", car_exited, 1'b1);
    checkOutput("s5_exit_uni", is_uni_car_exited, 1'b1);
    nextEdge();
    checkOutput("s5_exited_single", car_exited, 1'b0);
    @(negedge clk);
    step(5);

    // 6: reset while a car is under the entry barrier.
    $display("[TB] scenario 6: reset in passing");
    applyStimulus(0, 1, 0, 0, 0);
    step(10);
    applyStimulus(0, 1, 0, 1, 0);
    @(negedge clk);
    applyStimulus(0, 1, 1, 0, 0);
    step(12);
    checkOutput("s6_open_before_reset", in_barrier_open, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("s6_reset_closes", in_barrier_open, 1'b0);
    checkOutput("s6_reset_no_event", car_entered, 1'b0);
    step(3);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    sawEvent = 1'b0;
    repeat (20) begin
      nextEdge();
      if (car_entered) sawEvent = 1'b1;
    end
    checkOutput("s6_no_event_after_reset", sawEvent, 1'b0);
    @(negedge clk);

    $display("[TB] randomized traffic");
    fork
      laneRandom(0, 4000);
      laneRandom(1, 4000);
      flagsRandom(4000);
    join
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    step(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_gate_controller.md
# parking_gate_controller

Upstream front-end of `parking_management_system`. It runs one entry lane and one exit lane, each with a barrier, raw loop sensors and a badge reader. It debounces the sensors and gates entry on the downstream availability flags. Each completed passage becomes exactly one single-cycle `car_entered`/`car_exited` event with its university flag, and the block never issues an entry and an exit in the same cycle.

## Interface
- `DEBOUNCE_CYCLES`, 100_000 — consecutive stable cycles a synchronized sensor level needs before it is accepted (1 ms at 100 MHz).
- `PASS_TIMEOUT_CYCLES`, 1_500_000_000 — cycles an open barrier waits for the pass sensor to rise before it aborts (15 s).
- `clk` in 1 — clock.
- `reset` in 1 — reset, asynchronous, active-high.
- `in_arrive`, `in_pass` in 1 — raw entry loop sensors, asynchronous: `arrive` is before the barrier, `pass` is under it.
- `in_badge_valid` in 1 — entry badge strobe, one cycle, synchronous to `clk`.
- `in_badge_uni` in 1 — entry badge is a university car; qualified by `in_badge_valid`.
- `out_arrive`, `out_pass`, `out_badge_valid`, `out_badge_uni` in 1 — same meaning, exit lane.
- `uni_is_vacated_space`, `is_vacated_space` in 1 — availability flags from the management block.
- `in_barrier_open`, `out_barrier_open` out 1 — barrier drive, 1 = open.
- `car_entered`, `is_uni_car_entered` out 1 — entry event pulse and its flag.
- `car_exited`, `is_uni_car_exited` out 1 — exit event pulse and its flag.
- `in_reject` out 1 — one-cycle pulse: entry badge refused because there is no space.
- `in_timeout`, `out_timeout` out 1 — one-cycle pulse: a lane aborted with no passage.

## Operation
- Each sensor goes through a 2-flop synchronizer, then a debouncer.
  - A 32-bit counter counts while the synchronized level differs from the debounced level, and clears when they match.
  - The debounced level flips when the count reaches `DEBOUNCE_CYCLES`-1.
  - Debounced levels reset to 0.
- Lane FSM states:
  - IDLE → WAIT_BADGE when debounced `arrive` = 1.
  - WAIT_BADGE → IDLE when `arrive` drops to 0.
  - WAIT_BADGE, on `badge_valid`:
    - Exit lane: always go to OPEN.
    - Entry lane, university badge: go to OPEN if `uni_is_vacated_space`, otherwise pulse `in_reject` and stay in WAIT_BADGE.
    - Entry lane, non-university badge: same rule using `is_vacated_space`.
  - OPEN → PASSING on debounced `pass` rising edge.
  - OPEN → IDLE when the timeout counter reaches `PASS_TIMEOUT_CYCLES`-1, with a timeout pulse and no event.
  - PASSING → COMMIT on debounced `pass` falling edge. PASSING has no timeout.
  - COMMIT raises `req` with the latched uni flag and leaves to IDLE on `grant`.
- The badge uni flag is latched at acceptance. `badge_valid` outside WAIT_BADGE is ignored.
- `barrier_open` = 1 exactly in OPEN and PASSING.
- Arbiter:
  - Entry request has priority. An exit request in the same cycle is granted on the next cycle.
  - The `grant` is combinational. The event pulse and its uni flag are registered and asserted the cycle after `grant`, for 1 cycle.
  - The uni flag is 0 whenever the corresponding event is 0.
- Invariant: `car_entered & car_exited` is never 1.

## Timing
- Reset value of every output is 0. Lanes reset to IDLE, counters to 0, pending requests are dropped.
- Reset mid-operation closes the barriers within the reset assertion and emits no event.
- Raw `arrive` edge to WAIT_BADGE: 2 synchronizer cycles + `DEBOUNCE_CYCLES`.
- Badge accepted at cycle N: `barrier_open` = 1 at N+1. `in_reject` pulses at N+1.
- Debounced `pass` fall at cycle M:
  - COMMIT at M+1, barrier = 0 at M+1.
  - Event pulse at M+2 if granted, M+3 if deferred by the arbiter.
- The timeout counter is 32-bit, clears on entering OPEN and saturates; it never wraps.
- Availability flags are sampled only on the badge cycle. A flag change after acceptance does not close an open barrier.

## Structure
- Shared package `parking_pkg`:
  - lane state enum: IDLE, WAIT_BADGE, OPEN, PASSING, COMMIT;
  - default constants for `DEBOUNCE_CYCLES` and `PASS_TIMEOUT_CYCLES`;
  - the 32-bit counter width.
- One sub-module `gate_lane_fsm`, instantiated twice:
  - parameter `IS_ENTRY`;
  - contains both debouncers, the FSM, the timeout counter and the req/grant handshake.
- The top level holds the arbiter and the registered event outputs.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `PASS_TIMEOUT_CYCLES`=50.
1. Entry, university badge, `uni_is_vacated_space`=1, full arrive/pass/clear sequence → `in_barrier_open` high from badge+1 until pass fall+1; exactly one `car_entered`=1 with `is_uni_car_entered`=1.
2. Entry, non-university badge with `is_vacated_space`=0 → `in_reject` 1-cycle pulse, barrier stays 0, no event. Raise the flag, badge again → barrier opens.
3. Sensor glitches of 1–3 cycles on `arrive` and `pass` → no state change, no event.
4. Barrier open and `pass` never asserted → `in_timeout` pulse 50 cycles after open, barrier closes, no event.
5. Both lanes reach COMMIT in the same cycle → `car_entered` at cycle T, `car_exited` at T+1, never both high together.
6. Assert `reset` while in PASSING → all outputs 0 immediately; no event after reset is released.
